// File: rtl/uart_crc_checker.sv
// Length-prefixed frame parser behind the UART receiver: CRC-32 (reflected IEEE)
// over the payload, compared with a little-endian trailer, one status pulse per frame.
module uart_crc_checker #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        new_data,
  input  logic        parity_status,
  output logic        data_read,
  output logic [31:0] crc_out,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [1:0]  err_code,
  output logic        busy
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_CRC     = 2'd2;
  localparam logic [1:0] S_CHECK   = 2'd3;
  localparam int         TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] POLY     = 32'hEDB8_8320;

  logic [1:0]    state;
  logic          armed;
  logic [7:0]    cnt;
  logic [1:0]    idx;
  logic [31:0]   crc_reg;
  logic [31:0]   rx_crc;
  logic          par_flag;
  logic          force3;
  logic [TW-1:0] tcnt;
  logic          cap;
  logic          in_frame;
  logic          tmo;
  logic [31:0]   crc_next;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // armed blocks a second capture of the same pending byte while new_data stays high
  assign cap      = new_data && armed && (state != S_CHECK);
  assign in_frame = (state == S_PAYLOAD) || (state == S_CRC);
  assign tmo      = in_frame && !cap && (tcnt == TMAX);
  assign crc_next = crc_step(crc_reg, data_in);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      armed      <= 1'b1;
      cnt        <= '0;
      idx        <= '0;
      crc_reg    <= '0;
      rx_crc     <= '0;
      par_flag   <= 1'b0;
      force3     <= 1'b0;
      tcnt       <= '0;
      data_read  <= 1'b0;
      crc_out    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_code   <= '0;
    end else begin
      data_read  <= cap;
      frame_done <= 1'b0;
      if (cap)            armed <= 1'b0;
      else if (!new_data) armed <= 1'b1;
      if (!in_frame || cap) tcnt <= '0;
      else                  tcnt <= tcnt + TW'(1);

      if (tmo) begin
        frame_done <= 1'b1;
        frame_ok   <= 1'b0;
        err_code   <= 2'd3;
        state      <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (cap) begin
            if (data_in != 8'd0) begin
              cnt      <= data_in;
              crc_reg  <= 32'hFFFF_FFFF;
              par_flag <= 1'b0;
              rx_crc   <= '0;
              force3   <= 1'b0;
              state    <= S_PAYLOAD;
            end else begin
              force3 <= 1'b1;
              state  <= S_CHECK;
            end
          end
          S_PAYLOAD: if (cap) begin
            crc_reg  <= crc_next;
            par_flag <= par_flag | parity_status;
            cnt      <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              idx   <= '0;
              state <= S_CRC;
            end
          end
          S_CRC: if (cap) begin
            rx_crc[idx*8 +: 8] <= data_in;
            par_flag           <= par_flag | parity_status;
            idx                <= idx + 2'd1;
            if (idx == 2'd3) state <= S_CHECK;
          end
          default: begin
            frame_done <= 1'b1;
            state      <= S_IDLE;
            if (force3) begin
              frame_ok <= 1'b0;
              err_code <= 2'd3;
            end else begin
              crc_out <= ~crc_reg;
              if (par_flag) begin
                frame_ok <= 1'b0;
                err_code <= 2'd2;
              end else if (~crc_reg != rx_crc) begin
                frame_ok <= 1'b0;
                err_code <= 2'd1;
              end else begin
                frame_ok <= 1'b1;
                err_code <= 2'd0;
              end
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_crc_checker.sv
// Randomized frame stimulus scored against a byte-list reference model of the checker.
module tb_uart_crc_checker;
  logic        sys_clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  data_in = '0;
  logic        new_data = 1'b0;
  logic        parity_status = 1'b0;
  logic        data_read;
  logic [31:0] crc_out;
  logic        frame_done;
  logic        frame_ok;
  logic [1:0]  err_code;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0, rd_cnt = 0, fd_cnt = 0, last_rd_cyc = 0, fd_cyc = 0;
  logic [31:0] last_crc = '0;

  uart_crc_checker #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .reset(reset), .data_in(data_in), .new_data(new_data),
    .parity_status(parity_status), .data_read(data_read), .crc_out(crc_out),
    .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (data_read)  begin rd_cnt++; last_rd_cyc = cyc; end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: textbook reflected CRC-32 over a byte list
  function automatic logic [31:0] ref_crc(input byte unsigned d[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (d[i]) begin
      c ^= {24'd0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send_byte(input byte unsigned b, input bit p);
    int n0, t;
    repeat ($urandom_range(1, 3)) @(negedge sys_clk);
    data_in = b; parity_status = p; new_data = 1'b1;
    n0 = rd_cnt; t = 0;
    while (rd_cnt == n0 && t < 50) begin @(negedge sys_clk); t++; end
    if (t >= 50) chk("ack_wait", 32'(rd_cnt - n0), 1);
    new_data = 1'b0; parity_status = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int n0, input int lim);
    int t = 0;
    while (fd_cnt == n0 && t < lim) begin @(negedge sys_clk); t++; end
    chk({tag, "_fd"}, 32'(fd_cnt - n0), 1);
  endtask

  // corrupt: bit of received CRC to flip (-1 none); pidx: payload byte with parity error (-1 none)
  task automatic run_frame(input string tag, input byte unsigned pl[$], input int corrupt, input int pidx);
    logic [31:0] c, rx;
    int n_rd, n_fd;
    logic [1:0] e;
    c  = ref_crc(pl);
    rx = (corrupt >= 0) ? (c ^ (32'd1 << corrupt)) : c;
    e  = (pidx >= 0) ? 2'd2 : (corrupt >= 0) ? 2'd1 : 2'd0;
    n_rd = rd_cnt; n_fd = fd_cnt;
    send_byte(8'(pl.size()), 1'b0);
    foreach (pl[i]) send_byte(pl[i], i == pidx);
    for (int i = 0; i < 4; i++) send_byte(rx[i*8 +: 8], 1'b0);
    wait_fd(tag, n_fd, 20);
    last_crc = c;
    chk({tag, "_ok"},  {31'd0, frame_ok}, {31'd0, e == 2'd0});
    chk({tag, "_err"}, {30'd0, err_code}, {30'd0, e});
    chk({tag, "_crc"}, crc_out, last_crc);
    chk({tag, "_rd"},  32'(rd_cnt - n_rd), 32'(pl.size() + 5));
    chk({tag, "_lat"}, 32'(fd_cyc - last_rd_cyc), 1);
    repeat (3) @(negedge sys_clk);
    chk({tag, "_pulse"}, 32'(fd_cnt - n_fd), 1);
  endtask

  initial begin
    byte unsigned std[$];
    byte unsigned pl[$];
    int n_fd, n_rd;
    std = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    repeat (3) @(negedge sys_clk);
    chk("rst_outs", {data_read, frame_done, frame_ok, err_code, busy}, 0);
    chk("rst_crc", crc_out, 0);
    reset = 1'b1;
    @(negedge sys_clk);

    run_frame("good", std, -1, -1);
    chk("good_const", crc_out, 32'hCBF4_3926);
    run_frame("badcrc", std, 24, -1);
    run_frame("parity", std, 7, 2);

    // timeout after 5 bytes of a 9-byte frame
    n_fd = fd_cnt;
    send_byte(8'd9, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(std[i], 1'b0);
    wait_fd("tmo", n_fd, 40);
    chk("tmo_err", {30'd0, err_code}, 3);
    chk("tmo_ok", {31'd0, frame_ok}, 0);
    chk("tmo_crc", crc_out, last_crc);
    chk("tmo_lat", 32'(fd_cyc - last_rd_cyc), 16);
    run_frame("aftertmo", std, -1, -1);

    // LEN=0 held high for 10 cycles: one ack, err 3, crc_out untouched
    n_fd = fd_cnt; n_rd = rd_cnt;
    @(negedge sys_clk);
    data_in = 8'h00; new_data = 1'b1;
    repeat (10) @(negedge sys_clk);
    new_data = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("len0_rd", 32'(rd_cnt - n_rd), 1);
    chk("len0_fd", 32'(fd_cnt - n_fd), 1);
    chk("len0_lat", 32'(fd_cyc - last_rd_cyc), 1);
    chk("len0_err", {30'd0, err_code}, 3);
    chk("len0_crc", crc_out, last_crc);

    // reset mid-frame
    n_fd = fd_cnt;
    send_byte(8'd9, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(std[i], 1'b0);
    @(negedge sys_clk);
    reset = 1'b0;
    #1;
    chk("mrst_outs", {data_read, frame_done, frame_ok, err_code, busy}, 0);
    chk("mrst_crc", crc_out, 0);
    repeat (3) @(negedge sys_clk);
    reset = 1'b1;
    last_crc = '0;
    repeat (20) @(negedge sys_clk);
    chk("mrst_nofd", 32'(fd_cnt - n_fd), 0);
    run_frame("postrst", std, -1, -1);

    for (int f = 0; f < 8; f++) begin
      int len, cb, pi;
      len = $urandom_range(1, 16);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      cb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : -1;
      pi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_frame($sformatf("rnd%0d", f), pl, cb, pi);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
